// File: rtl/comp_edge_filter.sv
// Per-pixel comparator edge qualifier: synchroniser, glitch filter, polarity select,
// channel mask and one-shot-per-conversion latching with an all-done flag.
module comp_edge_filter #(
  parameter int NUM_PIXELS  = 5,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [1:0]            mode,
  input  logic [NUM_PIXELS-1:0] mask,
  input  logic [NUM_PIXELS-1:0] comp,
  output logic [NUM_PIXELS-1:0] enable,
  output logic [NUM_PIXELS-1:0] fired,
  output logic                  all_fired
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    MODE_RISE    = 2'b00,
    MODE_FALL    = 2'b01,
    MODE_BOTH    = 2'b10,
    MODE_DISABLE = 2'b11
  } mode_e;

  logic [NUM_PIXELS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PIXELS-1:0] sync_d [SYNC_STAGES];
  logic [NUM_PIXELS-1:0] sync_out;

  logic [NUM_PIXELS-1:0] filt_q, filt_d;
  logic [CW-1:0]         cnt_q [NUM_PIXELS];
  logic [CW-1:0]         cnt_d [NUM_PIXELS];
  logic [NUM_PIXELS-1:0] level_chg;
  logic [NUM_PIXELS-1:0] edge_match;
  logic [NUM_PIXELS-1:0] qualified;

  logic [NUM_PIXELS-1:0] enable_q, enable_d;
  logic [NUM_PIXELS-1:0] fired_q, fired_d;
  logic                  all_fired_q, all_fired_d;

  always_comb begin
    sync_d[0] = comp;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d    = filt_q;
    level_chg = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          filt_d[i]    = sync_out[i];
          level_chg[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    edge_match = '0;
    case (mode_e'(mode))
      MODE_RISE:    edge_match = level_chg & sync_out;
      MODE_FALL:    edge_match = level_chg & ~sync_out;
      MODE_BOTH:    edge_match = level_chg;
      MODE_DISABLE: edge_match = '0;
      default:      edge_match = '0;
    endcase

    // arm wins over a coincident edge, so that edge belongs to neither conversion
    qualified   = edge_match & mask & ~fired_q & {NUM_PIXELS{~arm}};
    enable_d    = qualified;
    fired_d     = arm ? '0 : (fired_q | qualified);
    all_fired_d = (mask != '0) && (&(fired_d | ~mask));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < NUM_PIXELS; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q      <= '0;
      enable_q    <= '0;
      fired_q     <= '0;
      all_fired_q <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < NUM_PIXELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q      <= filt_d;
      enable_q    <= enable_d;
      fired_q     <= fired_d;
      all_fired_q <= all_fired_d;
    end
  end

  assign enable    = enable_q;
  assign fired     = fired_q;
  assign all_fired = all_fired_q;

endmodule

// File: tb/tb_comp_edge_filter.sv
// Directed testbench for comp_edge_filter at default parameters (5 pixels, 2 sync, filter 2).
module tb_comp_edge_filter;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         arm;
  logic [1:0]   mode;
  logic [N-1:0] mask;
  logic [N-1:0] comp;
  logic [N-1:0] enable;
  logic [N-1:0] fired;
  logic         all_fired;

  int checks = 0;
  int errors = 0;
  int pulses [N];

  comp_edge_filter #(
    .NUM_PIXELS (N),
    .SYNC_STAGES(2),
    .FILTER_LEN (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .mode     (mode),
    .mask     (mask),
    .comp     (comp),
    .enable   (enable),
    .fired    (fired),
    .all_fired(all_fired)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < N; i++) pulses[i] = 0;
  end

  // Running tally of enable cycles per channel, used to count pulses over a window.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (enable[i] === 1'b1) pulses[i] = pulses[i] + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if (enable !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_enable: got %b want %b", enable, 5'b00000);
    end
    checks++;
    if (fired !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_fired: got %b want %b", fired, 5'b00000);
    end
    checks++;
    if (all_fired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_all_fired: got %b want %b", all_fired, 1'b0);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_basic_rise();
    arm_pulse();
    comp = 5'b00100;
    step(3);
    checks++;
    if (enable !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL basic_early: got %b want %b", enable, 5'b00000);
    end
    step(1);
    checks++;
    if (enable !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL basic_pulse: got %b want %b", enable, 5'b00100);
    end
    checks++;
    if (fired !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL basic_fired: got %b want %b", fired, 5'b00100);
    end
    step(1);
    checks++;
    if (enable !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL basic_one_cycle: got %b want %b", enable, 5'b00000);
    end
  endtask

  task automatic test_glitch();
    int p0;
    p0   = pulses[0];
    comp = 5'b00101;
    step(1);
    comp = 5'b00100;
    step(6);
    checks++;
    if (pulses[0] - p0 !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_short: pulses %0d want %0d", pulses[0] - p0, 0);
    end
    checks++;
    if (fired !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL glitch_short_fired: got %b want %b", fired, 5'b00100);
    end
    comp = 5'b00101;
    step(2);
    comp = 5'b00100;
    step(6);
    checks++;
    if (pulses[0] - p0 !== 1) begin
      errors++;
      $display("[TB] FAIL glitch_accept: pulses %0d want %0d", pulses[0] - p0, 1);
    end
    checks++;
    if (fired !== 5'b00101) begin
      errors++;
      $display("[TB] FAIL glitch_accept_fired: got %b want %b", fired, 5'b00101);
    end
  endtask

  task automatic test_one_shot();
    int p1;
    arm_pulse();
    checks++;
    if (fired !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL arm_clears: got %b want %b", fired, 5'b00000);
    end
    p1 = pulses[1];
    for (int ph = 0; ph < 4; ph++) begin
      comp[1] = ph[0];
      step(4);
    end
    step(6);
    checks++;
    if (pulses[1] - p1 !== 1) begin
      errors++;
      $display("[TB] FAIL one_shot_count: pulses %0d want %0d", pulses[1] - p1, 1);
    end
    checks++;
    if (fired !== 5'b00010) begin
      errors++;
      $display("[TB] FAIL one_shot_fired: got %b want %b", fired, 5'b00010);
    end
    arm_pulse();
    comp[1] = 1'b0;
    step(6);
    comp[1] = 1'b1;
    step(6);
    checks++;
    if (pulses[1] - p1 !== 2) begin
      errors++;
      $display("[TB] FAIL rearm_count: pulses %0d want %0d", pulses[1] - p1, 2);
    end
  endtask

  task automatic test_modes();
    comp = 5'b11111;
    step(6);
    arm_pulse();
    mode = 2'b01;
    comp = 5'b00000;
    step(3);
    checks++;
    if (enable !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL fall_early: got %b want %b", enable, 5'b00000);
    end
    step(1);
    checks++;
    if (enable !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL fall_pulse: got %b want %b", enable, 5'b11111);
    end
    checks++;
    if (all_fired !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fall_all_fired: got %b want %b", all_fired, 1'b1);
    end
    mode = 2'b10;
    arm_pulse();
    comp = 5'b11111;
    step(4);
    checks++;
    if (enable !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL both_rise: got %b want %b", enable, 5'b11111);
    end
    step(4);
    arm_pulse();
    comp = 5'b00000;
    step(4);
    checks++;
    if (enable !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL both_fall: got %b want %b", enable, 5'b11111);
    end
    step(4);
    mode = 2'b11;
    arm_pulse();
    comp = 5'b11111;
    step(6);
    checks++;
    if (fired !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL disabled_fired: got %b want %b", fired, 5'b00000);
    end
    mode = 2'b00;
    comp = 5'b00000;
    step(6);
  endtask

  task automatic test_mask();
    mask = 5'b10101;
    arm_pulse();
    comp = 5'b01011;
    step(6);
    checks++;
    if (fired !== 5'b00001 || all_fired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mask_first: got %b/%b want %b/%b", fired, all_fired, 5'b00001, 1'b0);
    end
    comp = 5'b01111;
    step(2);
    comp = 5'b11111;
    step(2);
    checks++;
    if (fired !== 5'b00101 || all_fired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mask_second: got %b/%b want %b/%b", fired, all_fired, 5'b00101, 1'b0);
    end
    step(1);
    checks++;
    if (all_fired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mask_not_yet: got %b want %b", all_fired, 1'b0);
    end
    step(1);
    checks++;
    if (enable !== 5'b10000 || fired !== 5'b10101 || all_fired !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mask_all: got %b/%b/%b want %b/%b/%b",
               enable, fired, all_fired, 5'b10000, 5'b10101, 1'b1);
    end
    mask = 5'b00000;
    step(1);
    checks++;
    if (all_fired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mask_zero: got %b want %b", all_fired, 1'b0);
    end
    mask = 5'b11111;
    comp = 5'b00000;
    step(6);
  endtask

  task automatic test_arm_coincident();
    arm_pulse();
    comp = 5'b01000;
    step(3);
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    checks++;
    if (enable !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL arm_coinc_enable: got %b want %b", enable, 5'b00000);
    end
    step(4);
    checks++;
    if (fired !== 5'b00000 || enable !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL arm_coinc_fired: got %b/%b want %b/%b", fired, enable, 5'b00000, 5'b00000);
    end
  endtask

  task automatic test_reset_mid();
    arm_pulse();
    comp = 5'b11111;
    step(4);
    checks++;
    if (enable !== 5'b10111 || fired !== 5'b10111) begin
      errors++;
      $display("[TB] FAIL pre_reset: got %b/%b want %b/%b", enable, fired, 5'b10111, 5'b10111);
    end
    step(2);
    reset = 1'b1;
    comp  = 5'b00001;
    step(1);
    checks++;
    if (enable !== 5'b00000 || fired !== 5'b00000 || all_fired !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %b/%b/%b want 00000/00000/0", enable, fired, all_fired);
    end
    step(1);
    reset = 1'b0;
    step(3);
    checks++;
    if (enable !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL powerup_early: got %b want %b", enable, 5'b00000);
    end
    step(1);
    checks++;
    if (enable !== 5'b00001 || fired !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL powerup_pulse: got %b/%b want %b/%b", enable, fired, 5'b00001, 5'b00001);
    end
  endtask

  initial begin
    reset = 1'b1;
    arm   = 1'b0;
    mode  = 2'b00;
    mask  = 5'b11111;
    comp  = 5'b00000;
    test_reset();
    test_basic_rise();
    test_glitch();
    test_one_shot();
    test_modes();
    test_mask();
    test_arm_coincident();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
